// File: rtl/pigro_pkg.sv
// Shared pipeline definitions: opcode encodings and opcode classification
// used by the write-back stage and its neighbours.
package pigro_pkg;

    localparam int OPC_BITS = 5;

    typedef enum logic [OPC_BITS-1:0] {
        OPC_NOP  = 5'd0,
        OPC_ADD  = 5'd1,
        OPC_SUB  = 5'd2,
        OPC_AND  = 5'd3,
        OPC_OR   = 5'd4,
        OPC_XOR  = 5'd5,
        OPC_LSH  = 5'd6,
        OPC_RSH  = 5'd7,
        OPC_ARSH = 5'd8,
        OPC_LDW  = 5'd9,
        OPC_STR  = 5'd10
    } opcode_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LOAD = 2'd2
    } opclass_e;

    // Opcodes arrive zero-extended to 16 bits so any OPC_W up to 16 can share these helpers.
    function automatic logic is_alu(input logic [15:0] op);
        return (op > 16'(OPC_NOP)) && (op <= 16'(OPC_ARSH));
    endfunction

    function automatic logic is_load(input logic [15:0] op);
        return (op == 16'(OPC_LDW));
    endfunction

    function automatic opclass_e op_class(input logic [15:0] op);
        if (is_alu(op)) begin
            return CLS_ALU;
        end
        if (is_load(op)) begin
            return CLS_LOAD;
        end
        return CLS_NONE;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular pending-write store with per-slot valid bits, exposing every
// entry so the owner can run a forwarding search across the whole queue.
module wb_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_pushData,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_headData,
    output logic [CNT_W-1:0]              o_count,
    output logic [PTR_W-1:0]              o_rdPtr,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]   o_entries
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0]            r_valid;
    logic [PTR_W-1:0]            r_wrPtr;
    logic [PTR_W-1:0]            r_rdPtr;
    logic [CNT_W-1:0]            r_count;

    logic w_doPush;
    logic w_doPop;

    assign w_doPush = i_push && (r_count < CNT_W'(DEPTH));
    assign w_doPop  = i_pop && (r_count != '0);

    // Payload storage needs no reset: the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_headData = r_mem[r_rdPtr];
    assign o_count    = r_count;
    assign o_rdPtr    = r_rdPtr;
    assign o_valid    = r_valid;
    assign o_entries  = r_mem;

endmodule

// File: rtl/wb_queue.sv
// Write-back stage: buffers register-file writes until the register file
// grants them, traces retirement, and forwards pending results.
module wb_queue
    import pigro_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4,
    parameter int PC_W   = 5,
    parameter int OPC_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPC_W-1:0]           in_opcode,
    input  logic [RA_W-1:0]            in_dest,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [DATA_W-1:0]          in_alu,
    input  logic [DATA_W-1:0]          in_lmd,
    output logic                       rf_we,
    output logic [RA_W-1:0]            rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    input  logic                       rf_grant,
    input  logic [RA_W-1:0]            fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic                       retire_valid,
    output logic [PC_W-1:0]            retire_pc,
    output logic [OPC_W-1:0]           retire_opcode,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int ENT_W = DATA_W + RA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        w_transfer;
    logic                        w_isAlu;
    logic                        w_isLoad;
    logic                        w_push;
    logic                        w_pop;
    logic [ENT_W-1:0]            w_pushEntry;
    logic [ENT_W-1:0]            w_headEntry;
    logic [CNT_W-1:0]            w_count;
    logic [PTR_W-1:0]            w_rdPtr;
    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][ENT_W-1:0] w_entries;
    logic [PTR_W-1:0]            w_slot;

    logic                        r_retireValid;
    logic [PC_W-1:0]             r_retirePc;
    logic [OPC_W-1:0]            r_retireOpcode;
    logic [RA_W-1:0]             r_lastAddr;
    logic [DATA_W-1:0]           r_lastData;

    assign w_isAlu    = is_alu(16'(in_opcode));
    assign w_isLoad   = is_load(16'(in_opcode));
    assign in_ready   = (w_count < CNT_W'(DEPTH));
    assign w_transfer = in_valid && in_ready;
    assign w_push     = w_transfer && (w_isAlu || w_isLoad);
    assign w_pushEntry = {in_dest, (w_isLoad ? in_lmd : in_alu)};
    assign rf_we      = (w_count != '0);
    assign w_pop      = rf_we && rf_grant;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushEntry),
        .i_pop      (w_pop),
        .o_headData (w_headEntry),
        .o_count    (w_count),
        .o_rdPtr    (w_rdPtr),
        .o_valid    (w_valid),
        .o_entries  (w_entries)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retireValid  <= 1'b0;
            r_retirePc     <= '0;
            r_retireOpcode <= '0;
        end else begin
            r_retireValid <= w_transfer;
            if (w_transfer) begin
                r_retirePc     <= in_pc;
                r_retireOpcode <= in_opcode;
            end
        end
    end

    // Remember the last presented write so the port holds steady once the queue drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastAddr <= '0;
            r_lastData <= '0;
        end else if (rf_we) begin
            r_lastAddr <= w_headEntry[ENT_W-1:DATA_W];
            r_lastData <= w_headEntry[DATA_W-1:0];
        end
    end

    assign rf_addr = rf_we ? w_headEntry[ENT_W-1:DATA_W] : r_lastAddr;
    assign rf_data = rf_we ? w_headEntry[DATA_W-1:0]     : r_lastData;

    // Walk oldest to youngest so the last match wins; the popping head still counts.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = w_rdPtr + PTR_W'(k);
            if (w_valid[w_slot] && (w_entries[w_slot][ENT_W-1:DATA_W] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_entries[w_slot][DATA_W-1:0];
            end
        end
    end

    assign retire_valid  = r_retireValid;
    assign retire_pc     = r_retirePc;
    assign retire_opcode = r_retireOpcode;
    assign count         = w_count;

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with scoreboards for register-file writes and
// retirement, checked by a negedge monitor independent of the stimulus.
module tb_wb_queue;
    import pigro_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [3:0]  in_dest;
    logic [4:0]  in_pc;
    logic [31:0] in_alu;
    logic [31:0] in_lmd;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_grant;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        retire_valid;
    logic [4:0]  retire_pc;
    logic [4:0]  retire_opcode;
    logic [2:0]  count;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [4:0] pc;
        logic [4:0] op;
    } ret_t;

    wr_t  expWr[$];
    ret_t expRet[$];
    int   checks = 0;
    int   errors = 0;
    bit   monOn = 0;
    bit   mReady;
    wr_t  wrTmp;
    ret_t retTmp;

    wb_queue #(
        .DATA_W (32),
        .RA_W   (4),
        .PC_W   (5),
        .OPC_W  (5),
        .DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_dest       (in_dest),
        .in_pc         (in_pc),
        .in_alu        (in_alu),
        .in_lmd        (in_lmd),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .rf_grant      (rf_grant),
        .fwd_addr      (fwd_addr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .retire_opcode (retire_opcode),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit enqueues(input logic [4:0] op);
        return ((op >= 5'd1) && (op <= 5'd8)) || (op == 5'd9);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one instruction for a single cycle; caller is just after a rising edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [3:0] dest, input logic [4:0] pc,
                                 input logic [31:0] alu, input logic [31:0] lmd);
        in_valid  = 1'b1;
        in_opcode = op;
        in_dest   = dest;
        in_pc     = pc;
        in_alu    = alu;
        in_lmd    = lmd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected-state tracker: records accepted transfers and granted pops at each edge.
    always @(posedge clk) begin
        if (rst) begin
            expWr.delete();
            expRet.delete();
        end else begin
            mReady = (expWr.size() < 4);
            if ((expWr.size() != 0) && rf_grant) begin
                wrTmp = expWr.pop_front();
            end
            if (in_valid && mReady) begin
                expRet.push_back('{in_pc, in_opcode});
                if (enqueues(in_opcode)) begin
                    expWr.push_back('{in_dest, (in_opcode == 5'd9) ? in_lmd : in_alu});
                end
            end
        end
    end

    // Monitor: compares the presented write and retirement trace against the scoreboards.
    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("count", 64'(count), 64'(expWr.size()));
            checkOutput("in_ready", 64'(in_ready), 64'(expWr.size() < 4));
            checkOutput("rf_we", 64'(rf_we), 64'(expWr.size() != 0));
            if (rf_we && (expWr.size() != 0)) begin
                checkOutput("rf_addr", 64'(rf_addr), 64'(expWr[0].addr));
                checkOutput("rf_data", 64'(rf_data), 64'(expWr[0].data));
            end
            checkOutput("retire_valid", 64'(retire_valid), 64'(expRet.size() != 0));
            if (expRet.size() != 0) begin
                retTmp = expRet.pop_front();
                if (retire_valid) begin
                    checkOutput("retire_pc", 64'(retire_pc), 64'(retTmp.pc));
                    checkOutput("retire_opcode", 64'(retire_opcode), 64'(retTmp.op));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_dest   = '0;
        in_pc     = '0;
        in_alu    = '0;
        in_lmd    = '0;
        rf_grant  = 1'b0;
        fwd_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        monOn = 1'b1;

        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_rf_we", 64'(rf_we), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_retire_valid", 64'(retire_valid), 64'd0);
        checkOutput("reset_retire_pc", 64'(retire_pc), 64'd0);
        checkOutput("reset_rf_addr", 64'(rf_addr), 64'd0);
        checkOutput("reset_rf_data", 64'(rf_data), 64'd0);
        checkOutput("reset_fwd_hit", 64'(fwd_hit), 64'd0);

        $display("[TB] single ALU write and load write");
        rf_grant = 1'b1;
        applyStimulus(OPC_ADD, 4'd3, 5'd1, 32'h0000_0011, 32'h0);
        checkOutput("add_rf_we", 64'(rf_we), 64'd1);
        checkOutput("add_rf_addr", 64'(rf_addr), 64'd3);
        checkOutput("add_rf_data", 64'(rf_data), 64'h11);
        checkOutput("add_retire_valid", 64'(retire_valid), 64'd1);
        checkOutput("add_retire_pc", 64'(retire_pc), 64'd1);
        applyStimulus(OPC_LDW, 4'd5, 5'd2, 32'h0000_0100, 32'hFFFF_FF80);
        checkOutput("ldw_rf_addr", 64'(rf_addr), 64'd5);
        checkOutput("ldw_rf_data", 64'(rf_data), 64'hFFFF_FF80);
        idle(2);
        checkOutput("empty_hold_addr", 64'(rf_addr), 64'd5);
        checkOutput("empty_hold_data", 64'(rf_data), 64'hFFFF_FF80);

        $display("[TB] non-writing opcodes");
        rf_grant = 1'b0;
        applyStimulus(OPC_STR, 4'd6, 5'd3, 32'h55, 32'h66);
        applyStimulus(OPC_NOP, 4'd7, 5'd4, 32'h77, 32'h88);
        applyStimulus(5'd20, 4'd8, 5'd5, 32'h99, 32'hAA);
        checkOutput("nowrite_count", 64'(count), 64'd0);
        checkOutput("nowrite_rf_we", 64'(rf_we), 64'd0);

        $display("[TB] fill, stall and refill");
        applyStimulus(OPC_ADD, 4'd1, 5'd6, 32'h1, 32'h0);
        applyStimulus(OPC_SUB, 4'd2, 5'd7, 32'h2, 32'h0);
        applyStimulus(OPC_AND, 4'd3, 5'd8, 32'h3, 32'h0);
        applyStimulus(OPC_ARSH, 4'd4, 5'd9, 32'h4, 32'h0);
        in_valid  = 1'b1;
        in_opcode = OPC_OR;
        in_dest   = 4'd6;
        in_pc     = 5'd10;
        in_alu    = 32'h6;
        in_lmd    = 32'h0;
        #3;
        checkOutput("full_count", 64'(count), 64'd4);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        idle(1);
        checkOutput("full_stall_count", 64'(count), 64'd4);
        rf_grant = 1'b1;
        idle(1);
        rf_grant = 1'b0;
        checkOutput("after_pop_count", 64'(count), 64'd3);
        checkOutput("after_pop_in_ready", 64'(in_ready), 64'd1);
        idle(1);
        in_valid = 1'b0;
        checkOutput("refill_count", 64'(count), 64'd4);
        rf_grant = 1'b1;
        idle(5);
        rf_grant = 1'b0;
        checkOutput("drained_rf_we", 64'(rf_we), 64'd0);
        checkOutput("drained_hold_addr", 64'(rf_addr), 64'd6);
        checkOutput("drained_hold_data", 64'(rf_data), 64'h6);

        $display("[TB] forwarding");
        applyStimulus(OPC_ADD, 4'd2, 5'd11, 32'hA, 32'h0);
        applyStimulus(OPC_ADD, 4'd2, 5'd12, 32'hB, 32'h0);
        applyStimulus(OPC_ADD, 4'd4, 5'd13, 32'hC, 32'h0);
        fwd_addr = 4'd2;
        #1;
        checkOutput("fwd2_hit", 64'(fwd_hit), 64'd1);
        checkOutput("fwd2_data", 64'(fwd_data), 64'hB);
        fwd_addr = 4'd7;
        #1;
        checkOutput("fwd7_hit", 64'(fwd_hit), 64'd0);
        checkOutput("fwd7_data", 64'(fwd_data), 64'h0);
        fwd_addr = 4'd4;
        #1;
        checkOutput("fwd4_data", 64'(fwd_data), 64'hC);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_opcode = OPC_ADD;
        in_dest   = 4'd7;
        in_pc     = 5'd14;
        in_alu    = 32'hD;
        fwd_addr  = 4'd7;
        #1;
        checkOutput("fwd_push_not_seen", 64'(fwd_hit), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("fwd_pushed_hit", 64'(fwd_hit), 64'd1);
        checkOutput("fwd_pushed_data", 64'(fwd_data), 64'hD);
        rf_grant = 1'b1;
        idle(2);
        fwd_addr = 4'd4;
        #1;
        checkOutput("fwd_popping_hit", 64'(fwd_hit), 64'd1);
        checkOutput("fwd_popping_data", 64'(fwd_data), 64'hC);
        @(posedge clk);
        #1;
        rf_grant = 1'b0;
        checkOutput("fwd_popped_hit", 64'(fwd_hit), 64'd0);
        checkOutput("fwd_popped_data", 64'(fwd_data), 64'h0);

        $display("[TB] reset mid-operation");
        applyStimulus(OPC_ADD, 4'd8, 5'd15, 32'h8, 32'h0);
        applyStimulus(OPC_XOR, 4'd9, 5'd16, 32'h9, 32'h0);
        checkOutput("prereset_count", 64'(count), 64'd3);
        rst = 1'b1;
        applyStimulus(OPC_ADD, 4'd10, 5'd17, 32'h10, 32'h0);
        rst = 1'b0;
        checkOutput("midreset_count", 64'(count), 64'd0);
        checkOutput("midreset_rf_we", 64'(rf_we), 64'd0);
        checkOutput("midreset_retire_valid", 64'(retire_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_rf_data", 64'(rf_data), 64'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DATA_W, 32, register-file data width.
REQ-002 SHALL have parameter RA_W, 4, register address width.
REQ-003 SHALL have parameter PC_W, 5, program-counter width.
REQ-004 SHALL have parameter OPC_W, 5, opcode width.
REQ-005 SHALL have parameter DEPTH, 4, pending-write queue depth (power of two, >=2).
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  in  1  upstream (memory stage) result valid.
REQ-009 SHALL have port in_ready  out  1  stage can accept this cycle.
REQ-010 SHALL have ports in_opcode  in  OPC_W; in_dest  in  RA_W; in_pc  in  PC_W  instruction tag.
REQ-011 SHALL have ports in_alu  in  DATA_W; in_lmd  in  DATA_W  signed ALU result and load data.
REQ-012 SHALL have ports rf_we  out  1; rf_addr  out  RA_W; rf_data  out  DATA_W  register-file write request.
REQ-013 SHALL have port rf_grant  in  1  register file accepts the presented write this cycle.
REQ-014 SHALL have ports fwd_addr  in  RA_W; fwd_hit  out  1; fwd_data  out  DATA_W  bypass lookup.
REQ-015 SHALL have ports retire_valid  out  1; retire_pc  out  PC_W; retire_opcode  out  OPC_W  retirement trace.
REQ-016 SHALL have port count  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-017 Transfer SHALL occur iff in_valid && in_ready at a rising edge; in_ready = (count < DEPTH), independent of in_valid and of rf_grant.
REQ-018 Opcode NOP<op<=ARSH SHALL enqueue {in_dest, in_alu}; LDW SHALL enqueue {in_dest, in_lmd}.
REQ-019 NOP, STR and any undefined opcode SHALL NOT enqueue and SHALL NOT write the register file.
REQ-020 Every transfer SHALL raise retire_valid for exactly one cycle, the cycle after acceptance, with retire_pc/retire_opcode = accepted values; otherwise retire_valid=0.
REQ-021 rf_we SHALL equal (count != 0); rf_addr/rf_data SHALL show the oldest entry (FIFO order).
REQ-022 Pop SHALL occur iff rf_we && rf_grant; entry enqueued at edge N is presentable at edge N+1 at earliest (write latency 1 cycle).
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order; pointers SHALL wrap modulo DEPTH.
REQ-024 Full (count==DEPTH): in_ready=0, pop still allowed; in_ready returns 1 in the cycle after the pop.
REQ-025 Empty: rf_we=0, rf_addr/rf_data hold last value, fwd_hit=0, rf_grant ignored.
REQ-026 fwd_hit SHALL be combinational: 1 iff some valid queue entry has dest==fwd_addr; fwd_data = data of the youngest matching entry; fwd_data=0 when no hit.
REQ-027 The entry being popped in the current cycle SHALL still count for forwarding in that cycle; an entry being pushed SHALL NOT.
REQ-028 Data SHALL pass unmodified at DATA_W; no sign extension or truncation.

Reset
REQ-029 While rst=1 at an edge: count=0, pointers=0, retire_valid=0, retire_pc=0, retire_opcode=0, rf_addr=0, rf_data=0; queue contents discarded.
REQ-030 Reset mid-operation SHALL drop all pending writes without asserting rf_we; in_ready=1 in the first cycle after reset deasserts.
REQ-031 A transfer presented in a reset cycle SHALL be ignored (no retire, no enqueue).

Structure
REQ-032 Opcode constants (NOP, ARSH, LDW, STR) SHALL come from the shared package pigro_pkg, alongside an opcode-class function (is_alu, is_load).
REQ-033 Storage and pointers SHALL be a sub-module wb_fifo (parameters DATA_W+RA_W, DEPTH) exposing entry valid/dest/data vectors for the forwarding search.

Verification (DATA_W=32, DEPTH=4)
REQ-034 ADD r3=0x0000_0011, rf_grant=1 -> next cycle rf_we=1, rf_addr=3, rf_data=0x11; retire_valid pulse with that PC.
REQ-035 LDW r5, in_lmd=0xFFFF_FF80, in_alu=0x100 -> rf_data=0xFFFF_FF80, never 0x100.
REQ-036 rf_grant=0, five back-to-back ALU ops -> count reaches 4, in_ready=0 on fifth; grant one cycle -> count 3, fifth accepted next edge, order preserved.
REQ-037 Queue holds r2=0xA then r2=0xB, fwd_addr=2 -> fwd_hit=1, fwd_data=0xB; fwd_addr=7 -> fwd_hit=0, fwd_data=0.
REQ-038 STR and NOP streamed -> retire_valid per instruction, rf_we stays 0, count stays 0.
REQ-039 rst=1 with count=3 -> next cycle count=0, rf_we=0, retire_valid=0, in_ready=1.
